// File: rtl/csr_arbiter.sv
// CSR access arbiter: one core CSR-instruction requester and one
// write-only trap requester sharing a single-port CSR array.
module csr_arbiter #(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 12
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              core_valid,
    output logic              core_ready,
    input  logic [IDX_W-1:0]  core_index,
    input  logic [2:0]        core_opcode,
    input  logic              core_ren,
    input  logic              core_wen,
    input  logic [WORD_W-1:0] core_reg_val,
    input  logic [4:0]        core_uimm,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic              rsp_illegal,
    input  logic              trap_valid,
    output logic              trap_ready,
    input  logic [IDX_W-1:0]  trap_index,
    input  logic [WORD_W-1:0] trap_wdata,
    output logic              csr_ren,
    output logic              csr_wen,
    output logic [IDX_W-1:0]  csr_addr,
    output logic [WORD_W-1:0] csr_wdata,
    input  logic [WORD_W-1:0] csr_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RESP,
        TWRITE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx_q;
    logic [2:0]        op_q;
    logic              ren_q;
    logic              wen_q;
    logic [WORD_W-1:0] val_q;
    logic [4:0]        uimm_q;
    logic [WORD_W-1:0] old_q;

    logic              illegal;
    logic [WORD_W-1:0] src;
    logic [WORD_W-1:0] old;
    logic [WORD_W-1:0] new_val;

    // Top two index bits 11 mark the read-only CSR space.
    assign illegal = (op_q[1:0] == 2'b00) ||
                     (wen_q && (idx_q[IDX_W-1 -: 2] == 2'b11));

    assign src = op_q[2] ? {{(WORD_W-5){1'b0}}, uimm_q} : val_q;
    assign old = (ren_q && !illegal) ? csr_rdata : '0;

    always_comb begin
        new_val = '0;
        case (op_q[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old | src;
            2'b11:   new_val = old & ~src;
            default: new_val = '0;
        endcase
    end

    // Trap data shares the index/value latches with the core request.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            idx_q  <= '0;
            op_q   <= '0;
            ren_q  <= 1'b0;
            wen_q  <= 1'b0;
            val_q  <= '0;
            uimm_q <= '0;
            old_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        idx_q <= trap_index;
                        val_q <= trap_wdata;
                        state <= TWRITE;
                    end else if (core_valid) begin
                        idx_q  <= core_index;
                        op_q   <= core_opcode;
                        ren_q  <= core_ren;
                        wen_q  <= core_wen;
                        val_q  <= core_reg_val;
                        uimm_q <= core_uimm;
                        state  <= READ;
                    end
                end
                READ:   state <= WRITE;
                WRITE: begin
                    old_q <= old;
                    state <= RESP;
                end
                RESP:   state <= IDLE;
                TWRITE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        trap_ready  = nrst && (state == IDLE);
        core_ready  = nrst && (state == IDLE) && !trap_valid;
        csr_ren     = 1'b0;
        csr_wen     = 1'b0;
        csr_addr    = '0;
        csr_wdata   = '0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_illegal = 1'b0;
        case (state)
            READ: begin
                csr_ren  = ren_q && !illegal;
                csr_addr = idx_q;
            end
            WRITE: begin
                csr_wen   = wen_q && !illegal;
                csr_addr  = idx_q;
                csr_wdata = new_val;
            end
            RESP: begin
                rsp_valid   = 1'b1;
                rsp_data    = old_q;
                rsp_illegal = illegal;
            end
            TWRITE: begin
                csr_wen   = 1'b1;
                csr_addr  = idx_q;
                csr_wdata = val_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_csr_arbiter.sv
// Directed bench for csr_arbiter with a behavioural single-port CSR array
// (one-cycle read latency).
module tb_csr_arbiter;

    logic        clk;
    logic        nrst;
    logic        core_valid;
    logic        core_ready;
    logic [11:0] core_index;
    logic [2:0]  core_opcode;
    logic        core_ren;
    logic        core_wen;
    logic [31:0] core_reg_val;
    logic [4:0]  core_uimm;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_illegal;
    logic        trap_valid;
    logic        trap_ready;
    logic [11:0] trap_index;
    logic [31:0] trap_wdata;
    logic        csr_ren;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    logic [31:0] mem [0:4095];
    logic        pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    int total;
    int bad;

    csr_arbiter #(.WORD_W(32), .IDX_W(12)) dut (
        .clk(clk),
        .nrst(nrst),
        .core_valid(core_valid),
        .core_ready(core_ready),
        .core_index(core_index),
        .core_opcode(core_opcode),
        .core_ren(core_ren),
        .core_wen(core_wen),
        .core_reg_val(core_reg_val),
        .core_uimm(core_uimm),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_illegal(rsp_illegal),
        .trap_valid(trap_valid),
        .trap_ready(trap_ready),
        .trap_index(trap_index),
        .trap_wdata(trap_wdata),
        .csr_ren(csr_ren),
        .csr_wen(csr_wen),
        .csr_addr(csr_addr),
        .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (csr_wen) mem[csr_addr] <= csr_wdata;
        if (csr_ren) csr_rdata <= mem[csr_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        pre_en = 1'b1;
        pre_addr = a;
        pre_data = d;
        step();
        pre_en = 1'b0;
    endtask

    task automatic drive_core(input logic [11:0] idx, input logic [2:0] op,
                              input logic ren, input logic wen,
                              input logic [31:0] rv, input logic [4:0] ui);
        core_index = idx;
        core_opcode = op;
        core_ren = ren;
        core_wen = wen;
        core_reg_val = rv;
        core_uimm = ui;
        core_valid = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        #3;
        total++;
        if (core_ready !== 1'b0 || trap_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_ready got=%b%b want=00", core_ready, trap_ready);
        end
        total++;
        if (rsp_valid !== 1'b0 || csr_wen !== 1'b0 || csr_ren !== 1'b0) begin
            bad++;
            $display("FAIL rst_outs got=%b%b%b want=000", rsp_valid, csr_wen, csr_ren);
        end
        step();
        step();
        nrst = 1'b1;
        #1;
        total++;
        if (core_ready !== 1'b1 || trap_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_release got=%b%b want=11", core_ready, trap_ready);
        end
    endtask

    task automatic test_csrrs();
        poke(12'h300, 32'h1);
        drive_core(12'h300, 3'b010, 1'b1, 1'b1, 32'h8, 5'h0);
        total++;
        if (core_ready !== 1'b1) begin
            bad++;
            $display("FAIL rs_ready got=%b want=1", core_ready);
        end
        step();
        core_valid = 1'b0;
        total++;
        if (csr_ren !== 1'b1 || csr_addr !== 12'h300 || csr_wen !== 1'b0) begin
            bad++;
            $display("FAIL rs_read got ren=%b addr=%h wen=%b want 1/300/0", csr_ren, csr_addr, csr_wen);
        end
        step();
        total++;
        if (csr_wen !== 1'b1 || csr_wdata !== 32'h9 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rs_write got wen=%b wdata=%h rv=%b want 1/9/0", csr_wen, csr_wdata, rsp_valid);
        end
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h1 || rsp_illegal !== 1'b0) begin
            bad++;
            $display("FAIL rs_resp got v=%b d=%h ill=%b want 1/1/0", rsp_valid, rsp_data, rsp_illegal);
        end
        step();
        total++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || mem[12'h300] !== 32'h9) begin
            bad++;
            $display("FAIL rs_after got v=%b d=%h mem=%h want 0/0/9", rsp_valid, rsp_data, mem[12'h300]);
        end
    endtask

    task automatic test_csrrci();
        poke(12'h341, 32'hF);
        drive_core(12'h341, 3'b111, 1'b1, 1'b1, 32'hFFFF_FFFF, 5'h03);
        step();
        core_valid = 1'b0;
        step();
        total++;
        if (csr_wen !== 1'b1 || csr_wdata !== 32'hC || csr_addr !== 12'h341) begin
            bad++;
            $display("FAIL rci_write got wen=%b wdata=%h addr=%h want 1/c/341", csr_wen, csr_wdata, csr_addr);
        end
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hF) begin
            bad++;
            $display("FAIL rci_resp got v=%b d=%h want 1/f", rsp_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_trap_priority();
        drive_core(12'h305, 3'b001, 1'b1, 1'b1, 32'h55, 5'h0);
        trap_valid = 1'b1;
        trap_index = 12'h305;
        trap_wdata = 32'hABCD;
        #1;
        total++;
        if (trap_ready !== 1'b1 || core_ready !== 1'b0) begin
            bad++;
            $display("FAIL tp_ready got t=%b c=%b want 1/0", trap_ready, core_ready);
        end
        step();
        trap_valid = 1'b0;
        total++;
        if (csr_wen !== 1'b1 || csr_addr !== 12'h305 || csr_wdata !== 32'hABCD || csr_ren !== 1'b0) begin
            bad++;
            $display("FAIL tp_twrite got wen=%b addr=%h wdata=%h ren=%b", csr_wen, csr_addr, csr_wdata, csr_ren);
        end
        total++;
        if (rsp_valid !== 1'b0 || core_ready !== 1'b0) begin
            bad++;
            $display("FAIL tp_twrite_rsp got v=%b cr=%b want 0/0", rsp_valid, core_ready);
        end
        step();
        total++;
        if (core_ready !== 1'b1 || csr_wen !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL tp_idle got cr=%b wen=%b v=%b want 1/0/0", core_ready, csr_wen, rsp_valid);
        end
        step();
        core_valid = 1'b0;
        trap_valid = 1'b1;
        trap_index = 12'h7C0;
        trap_wdata = 32'h1;
        total++;
        if (trap_ready !== 1'b0 || csr_ren !== 1'b1 || csr_wen !== 1'b0) begin
            bad++;
            $display("FAIL tp_read got tr=%b ren=%b wen=%b want 0/1/0", trap_ready, csr_ren, csr_wen);
        end
        step();
        total++;
        if (csr_wdata !== 32'h55 || csr_wen !== 1'b1 || csr_addr !== 12'h305) begin
            bad++;
            $display("FAIL tp_write got wdata=%h wen=%b addr=%h want 55/1/305", csr_wdata, csr_wen, csr_addr);
        end
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hABCD) begin
            bad++;
            $display("FAIL tp_resp got v=%b d=%h want 1/abcd", rsp_valid, rsp_data);
        end
        step();
        total++;
        if (trap_ready !== 1'b1 || mem[12'h305] !== 32'h55) begin
            bad++;
            $display("FAIL tp_late_trap got tr=%b mem=%h want 1/55", trap_ready, mem[12'h305]);
        end
        step();
        trap_valid = 1'b0;
        total++;
        if (csr_wen !== 1'b1 || csr_addr !== 12'h7C0 || csr_wdata !== 32'h1) begin
            bad++;
            $display("FAIL tp_late_tw got wen=%b addr=%h wdata=%h", csr_wen, csr_addr, csr_wdata);
        end
        step();
    endtask

    task automatic test_illegal();
        poke(12'hC00, 32'h77);
        drive_core(12'hC00, 3'b001, 1'b1, 1'b1, 32'h5, 5'h0);
        step();
        core_valid = 1'b0;
        total++;
        if (csr_ren !== 1'b0) begin
            bad++;
            $display("FAIL ro_read got ren=%b want 0", csr_ren);
        end
        step();
        total++;
        if (csr_wen !== 1'b0) begin
            bad++;
            $display("FAIL ro_write got wen=%b want 0", csr_wen);
        end
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_data !== 32'h0) begin
            bad++;
            $display("FAIL ro_resp got v=%b ill=%b d=%h want 1/1/0", rsp_valid, rsp_illegal, rsp_data);
        end
        step();
        total++;
        if (rsp_illegal !== 1'b0 || mem[12'hC00] !== 32'h77) begin
            bad++;
            $display("FAIL ro_after got ill=%b mem=%h want 0/77", rsp_illegal, mem[12'hC00]);
        end
        drive_core(12'h300, 3'b100, 1'b1, 1'b1, 32'h5, 5'h1);
        step();
        core_valid = 1'b0;
        step();
        total++;
        if (csr_wen !== 1'b0) begin
            bad++;
            $display("FAIL op0_write got wen=%b want 0", csr_wen);
        end
        step();
        total++;
        if (rsp_illegal !== 1'b1 || rsp_data !== 32'h0) begin
            bad++;
            $display("FAIL op0_resp got ill=%b d=%h want 1/0", rsp_illegal, rsp_data);
        end
        step();
    endtask

    task automatic test_write_only();
        poke(12'h340, 32'hDEAD);
        drive_core(12'h340, 3'b001, 1'b0, 1'b1, 32'h1234, 5'h0);
        step();
        core_valid = 1'b0;
        total++;
        if (csr_ren !== 1'b0) begin
            bad++;
            $display("FAIL wo_read got ren=%b want 0", csr_ren);
        end
        step();
        total++;
        if (csr_wen !== 1'b1 || csr_wdata !== 32'h1234 || csr_ren !== 1'b0) begin
            bad++;
            $display("FAIL wo_write got wen=%b wdata=%h ren=%b want 1/1234/0", csr_wen, csr_wdata, csr_ren);
        end
        step();
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0) begin
            bad++;
            $display("FAIL wo_resp got v=%b d=%h want 1/0", rsp_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_back_to_back();
        drive_core(12'h300, 3'b010, 1'b1, 1'b0, 32'h10, 5'h0);
        step();
        core_valid = 1'b0;
        step();
        total++;
        if (csr_wen !== 1'b0) begin
            bad++;
            $display("FAIL b2b_nowen got wen=%b want 0", csr_wen);
        end
        step();
        total++;
        if (rsp_data !== 32'h9) begin
            bad++;
            $display("FAIL b2b_resp1 got d=%h want 9", rsp_data);
        end
        drive_core(12'h341, 3'b110, 1'b1, 1'b1, 32'h0, 5'h10);
        step();
        total++;
        if (core_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got cr=%b v=%b want 1/0", core_ready, rsp_valid);
        end
        step();
        core_valid = 1'b0;
        total++;
        if (csr_ren !== 1'b1 || csr_addr !== 12'h341) begin
            bad++;
            $display("FAIL b2b_read got ren=%b addr=%h want 1/341", csr_ren, csr_addr);
        end
        step();
        total++;
        if (csr_wdata !== 32'h1C) begin
            bad++;
            $display("FAIL b2b_write got wdata=%h want 1c", csr_wdata);
        end
        step();
        total++;
        if (rsp_data !== 32'hC) begin
            bad++;
            $display("FAIL b2b_resp2 got d=%h want c", rsp_data);
        end
        step();
    endtask

    task automatic test_mid_reset();
        drive_core(12'h300, 3'b001, 1'b1, 1'b1, 32'hBEEF, 5'h0);
        step();
        core_valid = 1'b0;
        nrst = 1'b0;
        #1;
        total++;
        if (csr_ren !== 1'b0 || csr_addr !== 12'h0 || core_ready !== 1'b0) begin
            bad++;
            $display("FAIL mr_hold got ren=%b addr=%h cr=%b want 0/0/0", csr_ren, csr_addr, core_ready);
        end
        step();
        nrst = 1'b1;
        #1;
        total++;
        if (core_ready !== 1'b1) begin
            bad++;
            $display("FAIL mr_ready got=%b want 1", core_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (csr_wen !== 1'b0 || rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL mr_quiet%0d got wen=%b v=%b want 0/0", i, csr_wen, rsp_valid);
            end
        end
        total++;
        if (mem[12'h300] !== 32'h9) begin
            bad++;
            $display("FAIL mr_mem got=%h want 9", mem[12'h300]);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        nrst = 1'b0;
        core_valid = 1'b0;
        core_index = '0;
        core_opcode = '0;
        core_ren = 1'b0;
        core_wen = 1'b0;
        core_reg_val = '0;
        core_uimm = '0;
        trap_valid = 1'b0;
        trap_index = '0;
        trap_wdata = '0;
        pre_en = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        test_reset();
        test_csrrs();
        test_csrrci();
        test_trap_priority();
        test_illegal();
        test_write_only();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_arbiter.md
CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 SHALL have parameter WORD_W, default 32, CSR data width.
REQ-002 SHALL have parameter IDX_W, default 12, CSR index width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports core_valid in 1 / core_ready out 1, the core CSR-instruction request handshake.
REQ-006 SHALL have ports core_index in IDX_W, core_opcode in 3 (funct3), core_ren in 1, core_wen in 1, core_reg_val in WORD_W (rs1) and core_uimm in 5.
REQ-007 SHALL have ports rsp_valid out 1, rsp_data out WORD_W (old CSR value) and rsp_illegal out 1.
REQ-008 SHALL have ports trap_valid in 1, trap_ready out 1, trap_index in IDX_W and trap_wdata in WORD_W, the trap-unit write-only requester.
REQ-009 SHALL have ports csr_ren out 1, csr_wen out 1, csr_addr out IDX_W, csr_wdata out WORD_W and csr_rdata in WORD_W, the single-port CSR array.

Function
REQ-010 SHALL implement FSM states IDLE, READ, WRITE, RESP and TWRITE.
REQ-011 SHALL assert trap_ready only in IDLE, and core_ready only in IDLE with trap_valid=0: trap has fixed priority.
REQ-012 SHALL, on trap accept (IDLE, trap_valid=1), latch trap_index/trap_wdata and go to TWRITE.
REQ-013 SHALL, in TWRITE, drive csr_wen=1, csr_addr=latched index and csr_wdata=latched data for one cycle, then go to IDLE; no rsp_valid is produced.
REQ-014 SHALL, on core accept, latch all core_* fields and go to READ.
REQ-015 SHALL, in READ, drive csr_ren=core_ren, csr_addr=latched index and then go to WRITE.
REQ-016 SHALL, in WRITE, capture old = csr_rdata if latched ren=1 (array read latency 1 cycle), else old = 0.
REQ-017 SHALL compute src = zero-extended uimm when opcode[2]=1, else reg_val.
REQ-018 SHALL compute new value: opcode[1:0]=01 gives src; 10 gives old | src; 11 gives old & ~src.
REQ-019 SHALL, in WRITE, drive csr_wen=latched wen, csr_addr=index and csr_wdata=new value, then go to RESP.
REQ-020 SHALL, in RESP, drive rsp_valid=1 for exactly one cycle with rsp_data=old, then return to IDLE.
REQ-021 SHALL give a fixed latency of 3 cycles from the core accept edge to rsp_valid, regardless of ren/wen.
REQ-022 SHALL treat a request as illegal if opcode[1:0]=00, or if wen=1 with index[11:10]=11 (read-only CSR).
REQ-023 SHALL, for an illegal request, suppress csr_ren and csr_wen and still traverse READ/WRITE/RESP with rsp_illegal=1 and rsp_data=0.
REQ-024 SHALL never preempt an accepted core operation; a trap_valid arriving mid-sequence waits for IDLE.
REQ-025 SHALL accept trap_valid and core_valid both asserted in IDLE as trap first; the core request is accepted on the next IDLE cycle.
REQ-026 SHALL allow back-to-back operation: a new accept may occur in the IDLE cycle directly after RESP or TWRITE.
REQ-027 SHALL hold csr_ren, csr_wen, rsp_valid and rsp_illegal at 0 outside their designated states; rsp_data is 0 outside RESP.

Reset
REQ-028 SHALL, while nrst=0, force state=IDLE, all latched fields=0 and every output=0 (core_ready and trap_ready then follow REQ-011 after release).
REQ-029 SHALL, on reset asserted mid-operation, drop the in-flight request with no csr_wen and no rsp_valid after nrst deasserts.

Verification
REQ-030 SHALL cover: CSRRS (opcode 010), index 0x300, reg_val 0x8, array holds 0x1 -> csr_wen in WRITE with wdata 0x9; rsp_data 0x1 at accept+3.
REQ-031 SHALL cover: CSRRCI (opcode 111), uimm 5'h03, array holds 0xF -> wdata 0xC; rsp_data 0xF.
REQ-032 SHALL cover: trap_valid and core_valid high together in IDLE -> TWRITE first (csr_wen, trap data), then core accepted 1 cycle later; core rsp at its accept+3.
REQ-033 SHALL cover: wen=1 to index 0xC00 -> no csr_ren/csr_wen; rsp_illegal=1 with rsp_data=0 at accept+3.
REQ-034 SHALL cover: opcode 001 with ren=0 -> csr_ren never asserted; rsp_data=0; csr_wdata=reg_val.
REQ-035 SHALL cover: nrst pulled low during READ -> no csr_wen and no rsp_valid afterwards; core_ready=1 on the first cycle after release.
